pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting caches; legal range 2..8.
REQ-002 Parameter LINE_W, default 256: cacheline width in bits.
REQ-003 Parameter ADDR_W, default 32: address width in bits.
REQ-004 Port clk  input  1: sole clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-high.
REQ-006 Port req_read  input  [NUM_PORTS]: per-port line read request, held until that port's resp.
REQ-007 Port req_write  input  [NUM_PORTS]: per-port line write request, held until that port's resp.
REQ-008 Port req_addr  input  [NUM_PORTS][ADDR_W]: per-port line address.
REQ-009 Port req_wdata  input  [NUM_PORTS][LINE_W]: per-port write line.
REQ-010 Port req_resp  output  [NUM_PORTS]: one-cycle completion pulse to the granted port only.
REQ-011 Port req_rdata  output  LINE_W: shared read line; valid only while a req_resp bit is high.
REQ-012 Port pmem_read / pmem_write  output  1 each: request to the cacheline adapter.
REQ-013 Port pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W: request payload.
REQ-014 Port pmem_rdata  input  LINE_W; pmem_resp  input  1: adapter return data and completion.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-016 A port is pending when its req_read or req_write bit is high.
REQ-017 In IDLE with at least one pending port, the block SHALL grant one port, latch its index, address, wdata and op into registers, and enter BUSY on the next edge.
REQ-018 Port selection SHALL be round-robin: search from (last_grant+1) mod NUM_PORTS upward with wrap-around; last_grant updates on every grant.
REQ-019 If a port has both read and write high, the block SHALL perform the write.
REQ-020 In BUSY, pmem_read/pmem_write/pmem_address/pmem_wdata SHALL be driven only from the latched registers and held stable until pmem_resp.
REQ-021 On the BUSY cycle where pmem_resp=1, the block SHALL drive req_resp[grant]=1 and req_rdata=pmem_rdata combinationally, deassert pmem_read/pmem_write on the next edge, and return to IDLE.
REQ-022 Latency SHALL be: pending in IDLE cycle N -> pmem_read/pmem_write high in cycle N+1; a minimum of 2 cycles per transaction.
REQ-023 In IDLE, pmem_read, pmem_write and all req_resp bits SHALL be 0; a pmem_resp arriving in IDLE SHALL be ignored.
REQ-024 Request changes on the granted port while BUSY SHALL have no effect on the pmem outputs.
REQ-025 A port SHALL be granted at most once per transaction; a requester that still holds its request in the cycle after resp is treated as a new request.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, pmem_read=0, pmem_write=0, req_resp=0, and pmem_address/pmem_wdata/latched registers=0.
REQ-027 Reset SHALL set last_grant=NUM_PORTS-1 so that port 0 is searched first.
REQ-028 Reset during BUSY SHALL abandon the transaction with no req_resp pulse; the first grant after reset SHALL follow REQ-027.

Configuration
REQ-029 With macro PMEM_ARB_FIXED_PRIO_EN defined, selection SHALL be fixed priority with the highest index winning (data cache over instruction cache) and last_grant unused.
REQ-030 Without PMEM_ARB_FIXED_PRIO_EN, selection SHALL be round-robin per REQ-018.

Structure
REQ-031 The arb_state_e enum (IDLE, BUSY) and the MAX_ARB_PORTS=8 constant SHALL reside in the shared rv32i_types package.
REQ-032 Port selection SHALL be a combinational sub-module rr_picker(NUM_PORTS): inputs pending mask and last_grant; outputs valid and grant index. It contains the fixed-priority variant under the macro.

Verification
REQ-033 NUM_PORTS=2: port0 read addr 0x100, adapter resp after 3 cycles -> pmem_read high cycles 1-4, req_resp=2'b01 on the resp cycle, req_rdata equals pmem_rdata.
REQ-034 Ports 0 and 1 both pending continuously after reset, round-robin build -> grant order 0,1,0,1 and no port starved.
REQ-035 Same stimulus built with PMEM_ARB_FIXED_PRIO_EN -> port 1 granted on every transaction while it remains pending.
REQ-036 NUM_PORTS=4: port2 write 0x2A0 with wdata all 1s while port3 raises a read mid-BUSY -> pmem_wdata/pmem_address stay stable, then port3 is granted next.
REQ-037 rst asserted in BUSY -> pmem_read falls the same cycle with no req_resp; the next request goes to port 0 first.
REQ-038 pmem_resp pulsed in IDLE with no request -> req_resp stays 0 and state remains IDLE.

Source files
------------

// File: rtl/rv32i_types.sv
// ============================================================================
// Package     : rv32i_types
// Description : Shared types and constants for the memory-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int MAX_ARB_PORTS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/pmem_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational port selector. Round-robin starting after
//               last_grant, or fixed highest-index priority when
//               PMEM_ARB_FIXED_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 valid,
  output logic [IDX_W-1:0]     grant
);

`ifdef PMEM_ARB_FIXED_PRIO_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = ^last_grant;

  // Ascending scan so the highest pending index is the last one written.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pending[IDX_W'(i)]) begin
        valid = 1'b1;
        grant = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] w_idx;

  // Descending offset scan so the nearest port after last_grant wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    w_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
      if (pending[w_idx]) begin
        valid = 1'b1;
        grant = w_idx;
      end
    end
  end
`endif

endmodule : rr_picker

`default_nettype wire

// File: rtl/pmem_arbiter.sv
// ============================================================================
// Module      : pmem_arbiter
// Description : Arbitrates NUM_PORTS cacheline requesters onto one physical
//               memory adapter. Define PMEM_ARB_FIXED_PRIO_EN for fixed
//               highest-index priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [LINE_W-1:0]                req_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_W-1:0]                pmem_address,
  output logic [LINE_W-1:0]                pmem_wdata,
  input  logic [LINE_W-1:0]                pmem_rdata,
  input  logic                             pmem_resp
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_ARB_PORTS) begin : g_num_ports_check
    $error("pmem_arbiter: NUM_PORTS out of range");
  end

  arb_state_e           r_state;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_last_grant;
  logic [NUM_PORTS-1:0] w_pending;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_pick_idx;

  assign w_pending = req_read | req_write;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .pending    (w_pending),
    .last_grant (r_last_grant),
    .valid      (w_pick_valid),
    .grant      (w_pick_idx)
  );

  // pmem_read/pmem_write double as the latched op; address/wdata are the
  // latched payload, so the adapter only ever sees registered values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state      <= BUSY;
            r_grant      <= w_pick_idx;
            r_last_grant <= w_pick_idx;
            pmem_address <= req_addr[w_pick_idx];
            pmem_wdata   <= req_wdata[w_pick_idx];
            pmem_write   <= req_write[w_pick_idx];
            pmem_read    <= ~req_write[w_pick_idx];
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            r_state    <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_resp = '0;
    if (r_state == BUSY && pmem_resp) begin
      req_resp[r_grant] = 1'b1;
    end
  end

  assign req_rdata = pmem_rdata;

endmodule : pmem_arbiter

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
// ============================================================================
// Module      : tb_pmem_arbiter
// Description : Self-checking bench for pmem_arbiter against a transaction
//               level reference model (honours PMEM_ARB_FIXED_PRIO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmem_arbiter;

  localparam int NP = 4;
  localparam int LW = 64;
  localparam int AW = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NP-1:0]            req_read  = '0;
  logic [NP-1:0]            req_write = '0;
  logic [NP-1:0][AW-1:0]    req_addr  = '0;
  logic [NP-1:0][LW-1:0]    req_wdata = '0;
  logic [NP-1:0]            req_resp;
  logic [LW-1:0]            req_rdata;
  logic                     pmem_read;
  logic                     pmem_write;
  logic [AW-1:0]            pmem_address;
  logic [LW-1:0]            pmem_wdata;
  logic [LW-1:0]            pmem_rdata = '0;
  logic                     pmem_resp  = 1'b0;

  pmem_arbiter #(
    .NUM_PORTS (NP),
    .LINE_W    (LW),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_resp     (req_resp),
    .req_rdata    (req_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one outstanding transaction, described by its owner and payload.
  bit          m_busy    = 1'b0;
  int          m_grant   = 0;
  int          m_last    = NP - 1;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;
  bit          m_wr      = 1'b0;
  int          done_port = -1;
  int          grant_log[$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] pend, input int last);
`ifdef PMEM_ARB_FIXED_PRIO_EN
    for (int i = NP - 1; i >= 0; i--) if (pend[i]) return i;
`else
    for (int k = 1; k <= NP; k++) if (pend[(last + k) % NP]) return (last + k) % NP;
`endif
    return -1;
  endfunction

  // Called shortly after a rising edge; checks the cycle and advances one clock.
  task automatic step();
    logic [NP-1:0] exp_resp;
    int p;
    #1;
    exp_resp = '0;
    if (m_busy && pmem_resp) exp_resp[m_grant] = 1'b1;
    check("req_resp", LW'(req_resp), LW'(exp_resp));
    if (exp_resp != '0) check("req_rdata", req_rdata, pmem_rdata);
    if (!m_busy) begin
      p = pick(req_read | req_write, m_last);
      if (p >= 0) begin
        m_busy  = 1'b1;
        m_grant = p;
        m_last  = p;
        m_addr  = req_addr[p];
        m_wdata = req_wdata[p];
        m_wr    = req_write[p];
        grant_log.push_back(p);
      end
    end else if (pmem_resp) begin
      m_busy    = 1'b0;
      done_port = m_grant;
    end
    @(posedge clk);
    #1;
    check("pmem_read", LW'(pmem_read), LW'(m_busy && !m_wr));
    check("pmem_write", LW'(pmem_write), LW'(m_busy && m_wr));
    if (m_busy) begin
      check("pmem_address", LW'(pmem_address), LW'(m_addr));
      check("pmem_wdata", pmem_wdata, m_wdata);
    end
  endtask

  task automatic retire();
    if (done_port >= 0) begin
      req_read[done_port]  = 1'b0;
      req_write[done_port] = 1'b0;
    end
    done_port = -1;
  endtask

  task automatic do_reset_async();
    rst = 1'b1;
    #1;
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_req_resp", LW'(req_resp), '0);
    check("rst_pmem_address", LW'(pmem_address), '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    m_busy    = 1'b0;
    m_last    = NP - 1;
    done_port = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_stim();
    int op;
    retire();
    for (int p = 0; p < NP; p++) begin
      if (!(req_read[p] | req_write[p])) begin
        if ($urandom_range(0, 2) == 0) begin
          op           = int'($urandom_range(0, 2));
          req_read[p]  = (op != 1);
          req_write[p] = (op != 0);
          req_addr[p]  = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
          req_wdata[p] = {$urandom(), $urandom()};
        end
      end else if (m_busy && p == m_grant && $urandom_range(0, 3) == 0) begin
        req_addr[p]  = $urandom();
        req_wdata[p] = {$urandom(), $urandom()};
        req_write[p] = ~req_write[p];
        req_read[p]  = 1'b1;
      end
    end
    pmem_resp  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
    pmem_rdata = {$urandom(), $urandom()};
  endtask

  initial begin
    int exp_b[4];
    int exp_e;
`ifdef PMEM_ARB_FIXED_PRIO_EN
    exp_b = '{1, 1, 1, 1};
    exp_e = 3;
`else
    exp_b = '{0, 1, 0, 1};
    exp_e = 0;
`endif

    // Power-on reset values
    @(negedge clk);
    @(negedge clk);
    check("init_pmem_read", LW'(pmem_read), '0);
    check("init_pmem_write", LW'(pmem_write), '0);
    check("init_req_resp", LW'(req_resp), '0);
    check("init_pmem_address", LW'(pmem_address), '0);
    rst = 1'b0;

    // Single read from port 0, adapter answers after three busy cycles
    req_read[0] = 1'b1;
    req_addr[0] = 32'h100;
    step();
    check("a_addr_const", LW'(pmem_address), LW'(32'h100));
    check("a_read_high", LW'(pmem_read), LW'(1'b1));
    step(); step(); step();
    pmem_resp  = 1'b1;
    pmem_rdata = 64'hDEAD_BEEF_0123_4567;
    step();
    retire();
    pmem_resp = 1'b0;
    step();

    // Ports 0 and 1 held continuously from reset
    do_reset_async();
    grant_log.delete();
    req_read[0] = 1'b1; req_addr[0] = 32'h040;
    req_read[1] = 1'b1; req_addr[1] = 32'h080;
    for (int i = 0; i < 8; i++) begin
      pmem_resp = m_busy;
      step();
      done_port = -1;
    end
    for (int i = 0; i < 4; i++) check($sformatf("b_grant%0d", i), LW'(grant_log[i]), LW'(exp_b[i]));
    req_read = '0;
    pmem_resp = 1'b0;
    step();

    // Port 2 write, port 3 arrives mid-transaction, port 2 payload scrambled
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h2A0;
    req_wdata[2] = '1;
    step();
    req_read[3]  = 1'b1;
    req_addr[3]  = 32'h300;
    req_addr[2]  = 32'h5555;
    req_wdata[2] = '0;
    step();
    check("c_addr_stable", LW'(pmem_address), LW'(32'h2A0));
    check("c_wdata_stable", pmem_wdata, '1);
    step();
    pmem_resp = 1'b1;
    step();
    retire();
    pmem_resp = 1'b0;
    step();
    check("c_next_grant", LW'(grant_log[$]), LW'(3));
    pmem_resp = 1'b1;
    step();
    retire();

    // Adapter response while idle must be ignored
    pmem_resp = 1'b1;
    step();
    step();
    pmem_resp = 1'b0;

    // Reset while busy, then contention resolved from reset state
    req_read[1] = 1'b1;
    req_addr[1] = 32'h1C0;
    step();
    step();
    req_read[0] = 1'b1;
    req_read[3] = 1'b1;
    pmem_resp   = 1'b1;
    do_reset_async();
    pmem_resp = 1'b0;
    step();
    check("e_first_after_rst", LW'(grant_log[$]), LW'(exp_e));
    pmem_resp = 1'b1;
    step();
    retire();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_stim();
      if ($urandom_range(0, 399) == 0) do_reset_async();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pmem_arbiter

`default_nettype wire
